sar_controller: RTL and testbench
=================================

# sar_controller

Parametrised successive-approximation register (SAR) controller for the ADC path. It builds on the single enable flip-flop by holding a WIDTH-bit trial code whose bits are individually set and then kept or cleared. Decisions come from an external comparator. The block sequences sampling, per-bit DAC settling and comparator decisions, and publishes the converted code with a one-cycle done strobe.

## Interface
Parameters:
- WIDTH, 8, resolution in bits (≥2)
- SAMPLE_CYCLES, 2, cycles the track/hold `sample` output stays high (≥1)
- SETTLE_CYCLES, 1, cycles each trial code is held before the comparator is read (≥1)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  conversion request; accepted only in IDLE
- comp_in  in  1  comparator result; 1 = input ≥ DAC voltage (keep bit), 0 = clear bit
- sample  out  1  track/hold control, high during SAMPLE
- dac_code  out  WIDTH  trial code driven to the DAC
- busy  out  1  high in SAMPLE, CONVERT and DONE
- done  out  1  one-cycle pulse; result valid in that cycle
- result  out  WIDTH  last completed conversion, held until the next done

## Operation
- Reset values: state=IDLE, sample=0, dac_code=0, busy=0, done=0, result=0, internal code and bit index=0.
- The state machine has four states: IDLE, SAMPLE, CONVERT, DONE. All outputs are registered.
- IDLE:
  - sample=0, dac_code=0, busy=0.
  - start=1 at a clock edge moves to SAMPLE.
- SAMPLE:
  - sample=1, dac_code=0, busy=1.
  - Lasts exactly SAMPLE_CYCLES cycles, then moves to CONVERT with bit index i=WIDTH-1.
- CONVERT, per bit i from WIDTH-1 down to 0:
  - dac_code = kept bits above i, with bit i set, and lower bits 0.
  - The code is held for SETTLE_CYCLES cycles.
  - comp_in is sampled only at the edge ending the last settle cycle. 1 keeps bit i; 0 clears it.
  - comp_in values in earlier settle cycles are ignored.
- After the bit-0 decision:
  - result is loaded with the final code.
  - Next state is DONE: done=1 and busy=1 for one cycle, dac_code=0.
  - Then IDLE.
- start is ignored in SAMPLE, CONVERT and DONE; it is not queued.
- If start is still high in the first IDLE cycle after DONE, a new conversion begins.
- Reset asserted mid-conversion:
  - Every output is forced to its reset value asynchronously.
  - No done pulse is issued, result is cleared to 0, and the block returns to IDLE.
- Data width rules:
  - The code register is exactly WIDTH bits.
  - No arithmetic is performed; bits are only set or cleared.
  - result always equals the MSB-first binary-search outcome of the comparator decisions.

## Timing
- Cycle 0 is the cycle in which start=1 is sampled in IDLE.
- sample=1 in cycles 1 .. SAMPLE_CYCLES.
- Bit k = WIDTH-1-i (k from 0) occupies cycles SAMPLE_CYCLES+1+k·SETTLE_CYCLES through SAMPLE_CYCLES+(k+1)·SETTLE_CYCLES.
- done=1 in cycle L = 1 + SAMPLE_CYCLES + WIDTH·SETTLE_CYCLES (defaults: L=11). result changes in that same cycle.
- busy=1 in cycles 1 .. L; busy=0 in cycle L+1.
- With start held high continuously, the conversion period is L+1 cycles (defaults: 12).
- dac_code changes only at bit boundaries; it is stable for the full settle window.

## Test plan
- **Full scale, defaults:** comp_in=1 constantly, single start pulse → sample high cycles 1-2, dac_code 0x80,0xC0,…,0xFF in cycles 3-10, done in cycle 11 with result=0xFF, busy low in cycle 12.
- **Binary search:** model comparator comp_in = (dac_code ≤ 0xA5) → dac_code trial sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5 → result=0xA5 at done. Repeat with comp_in=0 constantly → result=0x00.
- **Busy protection and back-to-back:**
  - Pulse start in cycles 4 and 11 → exactly one conversion, no extra done.
  - Hold start high for 30 cycles → done in cycles 11 and 23, sample re-rises in cycle 13.
- **Reset mid-conversion:** assert reset asynchronously (between edges) in cycle 6 → sample, busy, done, dac_code and result all 0 immediately. No done pulse follows. A new start after release gives a correct conversion.
- **Parameter sweep:** WIDTH=12, SAMPLE_CYCLES=1, SETTLE_CYCLES=3, model input 0x5A3.
  - Toggle comp_in to the wrong value in the first two settle cycles of each bit.
  - Required: result=0x5A3, done in cycle 1+1+36=38.
  - Each dac_code value is held exactly 3 cycles.

Source files
------------

// File: rtl/sar_controller.sv
// rtl/sar_controller.sv - successive-approximation register controller
// Sequences sample, per-bit settle and comparator decisions; all outputs registered.
module sar_controller #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             comp_in,
  output logic             sample,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CMAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW   = $clog2(WIDTH);

  localparam logic [CW-1:0]    LAST_SAMPLE = CW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0]    LAST_SETTLE = CW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0]    TOP_BIT     = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE         = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB         = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CONVERT,
    ST_DONE
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [IW-1:0]    idx, idx_n;
  logic [WIDTH-1:0] code, code_n;
  logic             sample_n, busy_n, done_n;
  logic [WIDTH-1:0] dac_n, result_n;
  logic [WIDTH-1:0] bit_mask, decided;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      idx      <= '0;
      code     <= '0;
      sample   <= 1'b0;
      dac_code <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      code     <= code_n;
      sample   <= sample_n;
      dac_code <= dac_n;
      busy     <= busy_n;
      done     <= done_n;
      result   <= result_n;
    end
  end

  // The comparator only matters on the edge closing the last settle cycle of a bit.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    code_n   = code;
    sample_n = sample;
    dac_n    = dac_code;
    busy_n   = busy;
    done_n   = 1'b0;
    result_n = result;
    bit_mask = ONE << idx;
    decided  = comp_in ? code : (code & ~bit_mask);

    unique case (state)
      ST_IDLE: begin
        sample_n = 1'b0;
        dac_n    = '0;
        busy_n   = 1'b0;
        code_n   = '0;
        if (start) begin
          state_n  = ST_SAMPLE;
          cnt_n    = '0;
          sample_n = 1'b1;
          busy_n   = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (cnt == LAST_SAMPLE) begin
          state_n  = ST_CONVERT;
          cnt_n    = '0;
          idx_n    = TOP_BIT;
          code_n   = MSB;
          dac_n    = MSB;
          sample_n = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_CONVERT: begin
        if (cnt == LAST_SETTLE) begin
          cnt_n = '0;
          if (idx == '0) begin
            state_n  = ST_DONE;
            code_n   = decided;
            result_n = decided;
            done_n   = 1'b1;
            dac_n    = '0;
          end else begin
            // Next trial sets the bit just below the one being decided.
            idx_n  = idx - 1'b1;
            code_n = decided | (bit_mask >> 1);
            dac_n  = decided | (bit_mask >> 1);
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
        code_n  = '0;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sar_controller.sv
// tb/tb_sar_controller.sv - randomized model-checked bench for sar_controller
// Two instances (8/2/1 and 12/1/3) share start/reset; each has its own comparator.
module tb_sar_controller;

  logic        clk = 1'b0;
  logic        reset, start, comp_a, comp_b;
  logic        sample_a, busy_a, done_a, sample_b, busy_b, done_b;
  logic [7:0]  dac_a, result_a;
  logic [11:0] dac_b, result_b;

  always #5 clk = ~clk;

  sar_controller #(.WIDTH(8), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .comp_in(comp_a),
    .sample(sample_a), .dac_code(dac_a), .busy(busy_a), .done(done_a), .result(result_a));

  sar_controller #(.WIDTH(12), .SAMPLE_CYCLES(1), .SETTLE_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset), .start(start), .comp_in(comp_b),
    .sample(sample_b), .dac_code(dac_b), .busy(busy_b), .done(done_b), .result(result_b));

  int checks = 0, failures = 0;
  int pw[2] = '{8, 12};
  int ps[2] = '{2, 1};
  int pt[2] = '{1, 3};
  int vin[2];
  int mode;                 // 0 ideal, 1 ideal + wrong early settle values, 2 random, 3 all zero
  bit running[2];
  int tc[2], kept[2], lres[2], ndone[2], done_cyc[2];
  int cyc = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sample_a"}, int'(sample_a), 0);
    chk({tag, "_busy_a"},   int'(busy_a),   0);
    chk({tag, "_done_a"},   int'(done_a),   0);
    chk({tag, "_dac_a"},    int'(dac_a),    0);
    chk({tag, "_result_a"}, int'(result_a), 0);
    chk({tag, "_busy_b"},   int'(busy_b),   0);
    chk({tag, "_result_b"}, int'(result_b), 0);
  endtask

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      running[n] = 0; tc[n] = 0; kept[n] = 0; lres[n] = 0;
    end
  endtask

  // One cycle: check this cycle's outputs, choose comparator values, advance the model.
  task automatic step(input bit st);
    int ds[2], db[2], dd[2], ddac[2], dres[2];
    bit c[2];
    @(negedge clk);
    ds[0] = int'(sample_a); db[0] = int'(busy_a); dd[0] = int'(done_a);
    ddac[0] = int'(dac_a); dres[0] = int'(result_a);
    ds[1] = int'(sample_b); db[1] = int'(busy_b); dd[1] = int'(done_b);
    ddac[1] = int'(dac_b); dres[1] = int'(result_b);
    for (int n = 0; n < 2; n++) begin
      int es, eb, ed, edac, bi, len;
      bit dec, ideal;
      es = 0; eb = 0; ed = 0; edac = 0; bi = 0; dec = 0;
      len = 1 + ps[n] + pw[n] * pt[n];
      if (running[n]) begin
        eb = 1;
        es = (tc[n] <= ps[n]) ? 1 : 0;
        if (tc[n] == len) begin
          ed = 1;
          lres[n] = kept[n];
          ndone[n]++;
          done_cyc[n] = cyc;
        end else if (tc[n] > ps[n]) begin
          bi = pw[n] - 1 - (tc[n] - ps[n] - 1) / pt[n];
          edac = kept[n] | (1 << bi);
          dec = ((tc[n] - ps[n]) % pt[n]) == 0;
        end
      end
      chk($sformatf("sample_%0d", n), ds[n], es);
      chk($sformatf("busy_%0d", n), db[n], eb);
      chk($sformatf("done_%0d", n), dd[n], ed);
      chk($sformatf("dac_%0d", n), ddac[n], edac);
      chk($sformatf("result_%0d", n), dres[n], lres[n]);
      ideal = (edac <= vin[n]);
      case (mode)
        1:       c[n] = (edac != 0 && !dec) ? !ideal : ideal;
        2:       c[n] = 1'($urandom_range(0, 1));
        3:       c[n] = 1'b0;
        default: c[n] = ideal;
      endcase
      if (dec && c[n]) kept[n] |= (1 << bi);
      if (running[n]) begin
        if (tc[n] == len) running[n] = 0;
        else tc[n]++;
      end else if (st && !reset) begin
        running[n] = 1; tc[n] = 1; kept[n] = 0;
      end
    end
    comp_a = c[0];
    comp_b = c[1];
    start  = st;
    cyc++;
  endtask

  int c0, nd0, nd1;

  initial begin
    reset = 1'b1; start = 1'b0; comp_a = 1'b0; comp_b = 1'b0;
    mode = 0; vin[0] = 0; vin[1] = 0; ndone[0] = 0; ndone[1] = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    // Full scale
    vin[0] = 'hFF; vin[1] = 'hFFF; mode = 0;
    c0 = cyc; step(1'b1);
    repeat (41) step(1'b0);
    chk("full_result_a", int'(result_a), 'hFF);
    chk("full_result_b", int'(result_b), 'hFFF);
    chk("full_latency_a", done_cyc[0] - c0, 11);
    chk("full_latency_b", done_cyc[1] - c0, 38);

    // Binary search with wrong comparator values in early settle cycles
    vin[0] = 'hA5; vin[1] = 'h5A3; mode = 1;
    c0 = cyc; step(1'b1);
    repeat (41) step(1'b0);
    chk("search_result_a", int'(result_a), 'hA5);
    chk("search_result_b", int'(result_b), 'h5A3);
    chk("search_latency_b", done_cyc[1] - c0, 38);

    // Comparator always low
    mode = 3;
    step(1'b1);
    repeat (41) step(1'b0);
    chk("zero_result_a", int'(result_a), 0);
    chk("zero_result_b", int'(result_b), 0);

    // Start pulses while busy are ignored
    mode = 2; nd0 = ndone[0]; nd1 = ndone[1];
    step(1'b1);
    for (int k = 1; k < 42; k++) step(k == 4 || k == 11);
    chk("busy_protect_dones_a", ndone[0] - nd0, 1);
    chk("busy_protect_dones_b", ndone[1] - nd1, 1);

    // Start held high for 30 cycles
    mode = 0; vin[0] = $urandom_range(0, 255); vin[1] = $urandom_range(0, 4095);
    nd0 = ndone[0]; nd1 = ndone[1];
    repeat (30) step(1'b1);
    chk("held_dones_a_in_30", ndone[0] - nd0, 2);
    repeat (15) step(1'b0);
    chk("held_dones_a_total", ndone[0] - nd0, 3);
    chk("held_dones_b_total", ndone[1] - nd1, 1);

    // Reset asserted between edges in cycle 6 of a conversion
    step(1'b1);
    repeat (5) step(1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 model_reset();
    chk_all_zero("async_reset");
    step(1'b0);
    reset = 1'b0;
    nd0 = ndone[0];
    repeat (5) step(1'b0);
    chk("no_done_after_reset", ndone[0] - nd0, 0);
    vin[0] = $urandom_range(0, 255); vin[1] = $urandom_range(0, 4095);
    step(1'b1);
    repeat (41) step(1'b0);
    chk("post_reset_result_a", int'(result_a), vin[0]);
    chk("post_reset_result_b", int'(result_b), vin[1]);

    // Random starts and comparator decisions
    mode = 2;
    repeat (400) step($urandom_range(0, 3) == 0);
    repeat (45) step(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
